mac_dot_sched: RTL and testbench
================================

// Module: mac_dot_sched
// PURPOSE
//  Sequencer that drives one shared MAC datapath to compute a length-N dot product.
//  Operand pairs are read from an input-activation SRAM and a weight SRAM, both with 1-cycle read latency.
//  Each job is started by a command; the block clears the MAC, streams N operand pairs into it and captures the sum.
//  The result is returned on a valid/ready port; sits between the layer controller and the MAC/SRAM datapath.
// PARAMETERS
//  DATA_W  16  operand width (in_data / weight)
//  ACC_W   32  accumulator / result width
//  ADDR_W  10  SRAM address width
//  LEN_W   10  job length field width (N = 0 .. 2^LEN_W-1)
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  reset        in   1       asynchronous, active-high
//  cmd_valid    in   1       job request
//  cmd_ready    out  1       high only in IDLE; job accepted when cmd_valid & cmd_ready
//  cmd_in_base  in   ADDR_W  first activation address
//  cmd_w_base   in   ADDR_W  first weight address
//  cmd_len      in   LEN_W   number of operand pairs N
//  in_rd_en     out  1       activation SRAM read strobe
//  in_rd_addr   out  ADDR_W  activation SRAM address
//  in_rd_data   in   DATA_W  activation data, valid 1 cycle after in_rd_en
//  w_rd_en      out  1       weight SRAM read strobe
//  w_rd_addr    out  ADDR_W  weight SRAM address
//  w_rd_data    in   DATA_W  weight data, valid 1 cycle after w_rd_en
//  mac_clr      out  1       synchronous accumulator clear to MAC
//  mac_en       out  1       MAC accumulates mac_a*mac_b at this edge
//  mac_a        out  DATA_W  operand A (= in_rd_data)
//  mac_b        out  DATA_W  operand B (= w_rd_data)
//  mac_acc      in   ACC_W   registered MAC accumulator value
//  res_valid    out  1       result available
//  res_ready    in   1       consumer accepts result
//  res_data     out  ACC_W   dot-product result
//  busy         out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset:
//   - every output is 0 except cmd_ready = 1; res_data = 0; state = IDLE.
//  States: IDLE -> FETCH -> DRAIN -> CAPTURE -> RESULT -> IDLE.
//  IDLE:
//   - on accept, latch bases and N; counter i = 0.
//   - N != 0 -> FETCH; N == 0 -> RESULT with res_data = 0, no SRAM reads and no mac_clr.
//  FETCH:
//   - per cycle: in_rd_en = w_rd_en = 1, in_rd_addr = in_base + i, w_rd_addr = w_base + i.
//   - address sum wraps modulo 2^ADDR_W.
//   - mac_clr = 1 in the first FETCH cycle only; i increments each cycle.
//   - after the read with i = N-1 -> DRAIN.
//  mac_en:
//   - registered copy of the read strobe, so mac_en = 1 in FETCH cycles 2..N and in DRAIN.
//   - mac_a / mac_b are valid whenever mac_en = 1.
//   - mac_clr and the first mac_en are never asserted in the same cycle.
//  DRAIN:
//   - 1 cycle, last mac_en; no reads -> CAPTURE.
//  CAPTURE:
//   - 1 cycle; res_data <= mac_acc -> RESULT.
//  RESULT:
//   - res_valid = 1 and res_data held stable until res_valid & res_ready.
//   - on handshake: res_valid drops next cycle -> IDLE.
//   - res_ready may be held high in advance: handshake completes in the first RESULT cycle.
//  Latency:
//   - first read in the cycle after accept; res_valid rises N+3 cycles after the accept edge (N != 0).
//   - N == 0: res_valid rises 1 cycle after the accept edge.
//  cmd_valid while busy:
//   - ignored (cmd_ready = 0); no command queueing.
//   - next job can be accepted in the cycle after the result handshake.
//  Width rules:
//   - arithmetic overflow of the accumulator is the MAC's concern; res_data is mac_acc verbatim.
//  Reset mid-job:
//   - immediate return to IDLE; rd_en, mac_en, mac_clr and res_valid drop asynchronously.
//   - partial result discarded.
// TESTING
//  - Reset: assert reset -> cmd_ready = 1, busy = 0, all strobes 0, res_valid = 0, res_data = 0.
//  - N=4, bases 0/100, act={1,2,3,4}, wt={5,6,7,8} (behavioural MAC model)
//    -> reads at 0..3 / 100..103, one mac_clr, 4 mac_en, res_data = 70, res_valid at accept+7.
//  - N=3, in_base=1022 (ADDR_W=10) -> in_rd_addr sequence 1022, 1023, 0.
//  - N=0 -> no rd_en, no mac_clr/mac_en, res_valid at accept+1 with res_data = 0.
//  - res_ready held low 5 cycles, cmd_valid pulsed during job
//    -> res_valid/res_data stable, second cmd not accepted until after handshake.
//  - reset asserted in 3rd FETCH cycle of an N=8 job
//    -> strobes drop immediately, no res_valid; a following N=2 job completes correctly.

Source files
------------

// File: rtl/mac_dot_sched.sv
// Dot-product sequencer: fetches N operand pairs from the activation and weight SRAMs,
// streams them through a shared MAC and returns the accumulated sum on a valid/ready port.
module mac_dot_sched #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 10
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_in_base_i,
    input  logic [ADDR_W-1:0] cmd_w_base_i,
    input  logic [LEN_W-1:0]  cmd_len_i,

    output logic              in_rd_en_o,
    output logic [ADDR_W-1:0] in_rd_addr_o,
    input  logic [DATA_W-1:0] in_rd_data_i,
    output logic              w_rd_en_o,
    output logic [ADDR_W-1:0] w_rd_addr_o,
    input  logic [DATA_W-1:0] w_rd_data_i,

    output logic              mac_clr_o,
    output logic              mac_en_o,
    output logic [DATA_W-1:0] mac_a_o,
    output logic [DATA_W-1:0] mac_b_o,
    input  logic [ACC_W-1:0]  mac_acc_i,

    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [ACC_W-1:0]  res_data_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StCapture,
        StResult
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   in_base_q, in_base_d;
    logic [ADDR_W-1:0]   w_base_q, w_base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    res_data_q, res_data_d;
    logic                mac_en_q;
    logic                fetch;

    // State register; all strobes derive from these, so reset clears them asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            in_base_q  <= '0;
            w_base_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            mac_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_base_q  <= in_base_d;
            w_base_q   <= w_base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            mac_en_q   <= fetch;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_base_d  = in_base_q;
        w_base_d   = w_base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    in_base_d = cmd_in_base_i;
                    w_base_d  = cmd_w_base_i;
                    len_d     = cmd_len_i;
                    cnt_d     = '0;
                    if (cmd_len_i == '0) begin
                        res_data_d = '0;
                        state_d    = StResult;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                cnt_d = cnt_q + LEN_W'(1);
                if (cnt_q == len_q - LEN_W'(1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StCapture;
            end
            StCapture: begin
                // Last product was accumulated at the end of DRAIN; mac_acc is now final.
                res_data_d = mac_acc_i;
                state_d    = StResult;
            end
            StResult: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        fetch        = (state_q == StFetch);
        cmd_ready_o  = (state_q == StIdle);
        busy_o       = (state_q != StIdle);
        in_rd_en_o   = fetch;
        w_rd_en_o    = fetch;
        in_rd_addr_o = '0;
        w_rd_addr_o  = '0;
        if (fetch) begin
            in_rd_addr_o = in_base_q + ADDR_W'(cnt_q);
            w_rd_addr_o  = w_base_q + ADDR_W'(cnt_q);
        end
        mac_clr_o   = fetch && (cnt_q == '0);
        mac_en_o    = mac_en_q;
        mac_a_o     = mac_en_q ? in_rd_data_i : '0;
        mac_b_o     = mac_en_q ? w_rd_data_i : '0;
        res_valid_o = (state_q == StResult);
        res_data_o  = res_data_q;
    end

endmodule

// File: tb/tb_mac_dot_sched.sv
// Directed bench for mac_dot_sched with behavioural SRAMs and MAC.
module tb_mac_dot_sched;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_in_base;
    logic [ADDR_W-1:0] cmd_w_base;
    logic [LEN_W-1:0]  cmd_len;
    logic              in_rd_en;
    logic [ADDR_W-1:0] in_rd_addr;
    logic [DATA_W-1:0] in_rd_data;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic              mac_clr;
    logic              mac_en;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [ACC_W-1:0]  mac_acc;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] act_mem [1024];
    logic [DATA_W-1:0] wt_mem  [1024];

    logic [ADDR_W-1:0] in_q[$];
    logic [ADDR_W-1:0] w_q[$];
    int clr_cnt, en_cnt, both_cnt, rv_cnt;

    always #5 clk = ~clk;

    mac_dot_sched #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_in_base_i(cmd_in_base),
        .cmd_w_base_i (cmd_w_base),
        .cmd_len_i    (cmd_len),
        .in_rd_en_o   (in_rd_en),
        .in_rd_addr_o (in_rd_addr),
        .in_rd_data_i (in_rd_data),
        .w_rd_en_o    (w_rd_en),
        .w_rd_addr_o  (w_rd_addr),
        .w_rd_data_i  (w_rd_data),
        .mac_clr_o    (mac_clr),
        .mac_en_o     (mac_en),
        .mac_a_o      (mac_a),
        .mac_b_o      (mac_b),
        .mac_acc_i    (mac_acc),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data),
        .busy_o       (busy)
    );

    // 1-cycle-latency SRAMs and a behavioural MAC.
    always @(posedge clk) begin
        if (in_rd_en) in_rd_data <= act_mem[in_rd_addr];
        if (w_rd_en)  w_rd_data  <= wt_mem[w_rd_addr];
    end

    always @(posedge clk or posedge reset) begin
        if (reset)        mac_acc <= '0;
        else if (mac_clr) mac_acc <= '0;
        else if (mac_en)  mac_acc <= mac_acc + ACC_W'(mac_a) * ACC_W'(mac_b);
    end

    always @(negedge clk) begin
        if (in_rd_en) in_q.push_back(in_rd_addr);
        if (w_rd_en)  w_q.push_back(w_rd_addr);
        if (mac_clr) clr_cnt++;
        if (mac_en) en_cnt++;
        if (mac_clr && mac_en) both_cnt++;
        if (res_valid) rv_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        in_q.delete();
        w_q.delete();
        clr_cnt  = 0;
        en_cnt   = 0;
        both_cnt = 0;
        rv_cnt   = 0;
    endtask

    task automatic wait_result(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!res_valid && k < 100);
    endtask

    task automatic run_job(input string tag, input logic [ADDR_W-1:0] ib,
                           input logic [ADDR_W-1:0] wb, input logic [LEN_W-1:0] n,
                           input logic [ACC_W-1:0] exp_res, input bit early);
        int k;
        int exp_lat;
        exp_lat = (n == 0) ? 1 : int'(n) + 3;
        clear_mon();
        res_ready = early;
        @(negedge clk);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_in_base = ib;
        cmd_w_base  = wb;
        cmd_len     = n;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1;
        if (!res_valid) begin
            wait_result(k);
            k++;
        end
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_res_data"}, res_data, exp_res);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_n_in_reads"}, in_q.size(), n);
        chk({tag, "_n_w_reads"}, w_q.size(), n);
        if (in_q.size() == int'(n) && w_q.size() == int'(n)) begin
            for (int i = 0; i < int'(n); i++) begin
                chk({tag, "_in_addr"}, in_q[i], ADDR_W'(ib + ADDR_W'(i)));
                chk({tag, "_w_addr"}, w_q[i], ADDR_W'(wb + ADDR_W'(i)));
            end
        end
        chk({tag, "_clr_cnt"}, clr_cnt, (n == 0) ? 0 : 1);
        chk({tag, "_en_cnt"}, en_cnt, n);
        chk({tag, "_clr_en_overlap"}, both_cnt, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, res_valid, 0);
        chk({tag, "_idle_ready"}, cmd_ready, 1);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int k;
        for (int a = 0; a < 1024; a++) begin
            act_mem[a] = '0;
            wt_mem[a]  = '0;
        end
        act_mem[0] = 1; act_mem[1] = 2; act_mem[2] = 3; act_mem[3] = 4;
        wt_mem[100] = 5; wt_mem[101] = 6; wt_mem[102] = 7; wt_mem[103] = 8;
        act_mem[1022] = 10; act_mem[1023] = 20;
        wt_mem[200] = 2; wt_mem[201] = 3; wt_mem[202] = 4;
        act_mem[5] = 9; wt_mem[105] = 11;

        reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_in_base = '0; cmd_w_base = '0; cmd_len = '0;
        clear_mon();
        #3;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {in_rd_en, w_rd_en, mac_clr, mac_en}, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_addrs", {in_rd_addr, w_rd_addr}, 0);
        #20;
        @(negedge clk);
        reset = 1'b0;

        run_job("n4", 10'd0, 10'd100, 10'd4, 32'd70, 1'b0);
        run_job("wrap", 10'd1022, 10'd200, 10'd3, 32'd84, 1'b0);
        run_job("n0", 10'd7, 10'd9, 10'd0, 32'd0, 1'b0);
        run_job("early_rdy", 10'd5, 10'd105, 10'd1, 32'd99, 1'b1);

        // Result stall with a competing command held throughout the job.
        clear_mon();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_in_base = 10'd2; cmd_w_base = 10'd102; cmd_len = 10'd2;
        @(negedge clk);
        cmd_in_base = 10'd50; cmd_w_base = 10'd60; cmd_len = 10'd5;
        k = 1;
        wait_result(k);
        k++;
        chk("stall_latency", k, 5);
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", res_valid, 1);
            chk("stall_data", res_data, 53);
            chk("stall_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        chk("stall_valid_end", res_valid, 1);
        chk("stall_n_reads", in_q.size(), 2);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("stall_valid_drop", res_valid, 0);
        chk("stall_idle_ready", cmd_ready, 1);
        @(negedge clk);
        chk("stall_no_second_job", busy, 0);
        chk("stall_total_reads", in_q.size(), 2);

        // Reset in the third FETCH cycle of an N=8 job.
        clear_mon();
        cmd_valid = 1'b1; cmd_in_base = 10'd0; cmd_w_base = 10'd100; cmd_len = 10'd8;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_pre_rd_en", in_rd_en, 1);
        chk("mid_pre_mac_en", mac_en, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_strobes", {in_rd_en, w_rd_en, mac_clr, mac_en}, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_no_result", rv_cnt, 0);
        chk("mid_partial_reads", in_q.size(), 3);
        run_job("after_rst", 10'd0, 10'd100, 10'd2, 32'd17, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
